move_scheduler: RTL and testbench
=================================

# move_scheduler

Sequences move commands into the 2048 game-logic core. It arbitrates between three requesters (debounced local buttons, gamepad, and debug controller), holds at most one pending move per requester, and issues one move at a time over a valid/ready handshake. After each move it waits for the core's completion and then for a frame boundary before issuing the next move, so every move is displayed. It sits between the input front-ends and `game_logic`, and replaces the ad-hoc OR of button sources.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1023: maximum number of cycles spent in WAIT_DONE before the move is abandoned.
- `FRAME_GAP`, default 1: number of `frame_tick` pulses to wait after `move_done` before returning to IDLE. A value of 0 skips the wait.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `btn_lvl`  in  4  debounced local button levels {right,left,down,up}.
- `pad_lvl`  in  4  gamepad direction levels, same bit order.
- `dbg_pulse`  in  4  debug force-move pulses, one-hot, same bit order.
- `lock`  in  1  welcome screen active; human moves are blocked.
- `frame_tick`  in  1  one-cycle vsync rising-edge strobe.
- `move_valid`  out  1  a move is offered to the core.
- `move_dir`  out  2  direction: 0=up, 1=down, 2=left, 3=right.
- `move_dbg`  out  1  the offered move originated from debug.
- `move_ready`  in  1  the core accepts the move.
- `move_done`  in  1  one-cycle strobe: the core finished the move, including tile insertion.
- `start_pulse`  out  1  one-cycle strobe: a human press arrived while `lock` was high.
- `busy`  out  1  the scheduler is in any state other than IDLE.
- `timeout_err`  out  1  one-cycle strobe when the WAIT_DONE timeout fires.

## Operation
- **Human edge detect.** A rising edge is `lvl & ~prev`, evaluated per bit. `prev` resets to 4'b1111, so a button held through reset produces no move until it is released and pressed again.
- **Multi-bit edges.** If an edge event has several bits set, the lowest index wins: up > down > left > right.
- **Pending slots.** Each source has one pending slot holding {valid, dir}. A new edge or pulse overwrites that source's slot (latest wins).
- **Lock.** While `lock`=1, a human edge does not set a slot and instead produces `start_pulse`. Debug pulses are accepted regardless of `lock`. A rising edge of `lock` clears both human slots.
- **Arbitration.** Arbitration happens in IDLE only. Fixed priority is dbg > btn > pad. The winning slot is cleared on the cycle the scheduler enters ISSUE.
- **States:**
  - IDLE: if any slot is valid, load `move_dir`/`move_dbg` and go to ISSUE.
  - ISSUE: `move_valid`=1. On `move_valid && move_ready`, go to WAIT_DONE and clear the timeout counter.
  - WAIT_DONE: on `move_done`, go to WAIT_FRAME, or to IDLE if `FRAME_GAP`=0. If the counter reaches `TIMEOUT_CYCLES`, pulse `timeout_err` and go to IDLE.
  - WAIT_FRAME: count `frame_tick` pulses; on the `FRAME_GAP`-th pulse, go to IDLE.
- **Stray strobes.** `move_done` in any state other than WAIT_DONE is ignored.
- **Counter widths.** The timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits and the frame counter is `$clog2(FRAME_GAP+1)` bits (minimum 1). Neither wraps; both saturate at their terminal value.
- **Slots while busy.** Slots keep capturing while the scheduler is busy, so each source has a one-deep queue.

## Timing
- **Reset values.** All outputs are 0, the state is IDLE, all slots are empty, and both counters are 0.
- **Latency.** An edge sampled at cycle N sets its slot at N+1. `move_valid` rises at N+2 if the scheduler is idle.
- **Handshake.**
  - `move_dir` and `move_dbg` are registered and stable for the whole time `move_valid` is high.
  - `move_valid` is held until `move_ready`.
  - It drops the cycle after the transfer and is never re-asserted for the same move.
- **Same-cycle overwrite.** A new edge in the same cycle as the winner's slot being cleared is captured, i.e. the new edge wins over the clear.
- **Same-cycle lock.** If a `lock` rising edge coincides with a human edge, the slots are cleared and `start_pulse` fires.
- **Frame tick during done.** A `frame_tick` in the same cycle as `move_done` does not count toward `FRAME_GAP`.
- **Reset mid-move.** Reset returns to IDLE immediately. No `move_valid` or `timeout_err` is generated after reset.

## Structure
- **Shared package `move_pkg`:**
  - direction encoding constants DIR_UP/DOWN/LEFT/RIGHT;
  - state encoding S_IDLE/S_ISSUE/S_WAIT_DONE/S_WAIT_FRAME;
  - a function that converts a 4-bit edge vector to a 2-bit direction.
- **Sub-module `move_src_capture`:** edge detect, lock gating, and the pending slot. It is instantiated once for btn and once for pad. The debug slot is inline.

## Test plan
- Press `btn_lvl`=4'b0001 at cycle 10 with `move_ready` tied high: `move_valid`=1 with dir=0 at cycle 12 for exactly 1 cycle. After `move_done` at 20 and `FRAME_GAP`=1, `busy` drops one cycle after the next `frame_tick`.
- Raise `dbg_pulse`=4'b1000 and `pad_lvl`=4'b0010 in the same cycle: the debug move is issued first (dir=3, `move_dbg`=1), then the pad move (dir=1) after its completion and frame wait.
- With `lock`=1, press the up button: `start_pulse`=1 for one cycle and no `move_valid`. Then set `lock`=0 and press left: dir=2 is issued.
- Never assert `move_done` with `TIMEOUT_CYCLES`=15: `timeout_err` pulses 15 cycles after the transfer, the scheduler is back in IDLE, and the next queued move is issued.
- Press btn up then btn right during WAIT_DONE: only dir=3 is issued next (overwrite). A button held through reset produces no move until it is released and pressed again.
- Hold `move_ready`=0 for 50 cycles: `move_valid` and `move_dir` stay constant; assert reset mid-ISSUE and all outputs read 0 on the next cycle.

Source files
------------

// File: rtl/move_pkg.sv
// rtl/move_pkg.sv - shared encodings for the move scheduler
package move_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_ISSUE      = 2'd1,
    S_WAIT_DONE  = 2'd2,
    S_WAIT_FRAME = 2'd3
  } state_e;

  // Lowest set bit wins: up > down > left > right.
  function automatic logic [1:0] edge_to_dir(input logic [3:0] ev);
    if (ev[0])      return DIR_UP;
    else if (ev[1]) return DIR_DOWN;
    else if (ev[2]) return DIR_LEFT;
    else            return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/move_src_capture.sv
// rtl/move_src_capture.sv - human source edge detect, lock gating and pending slot
module move_src_capture
  import move_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] lvl_i,
  input  logic       lock_i,
  input  logic       clear_i,
  output logic       slot_valid_o,
  output logic [1:0] slot_dir_o,
  output logic       press_locked_o
);

  logic [3:0] prev_q;
  logic       lock_q;
  logic       valid_q;
  logic [1:0] dir_q;
  logic [3:0] edges;
  logic       lock_rise;

  assign edges          = lvl_i & ~prev_q;
  assign lock_rise      = lock_i & ~lock_q;
  assign press_locked_o = (|edges) & lock_i;
  assign slot_valid_o   = valid_q;
  assign slot_dir_o     = dir_q;

  // prev resets high so a level held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q  <= 4'b1111;
      lock_q  <= 1'b0;
      valid_q <= 1'b0;
      dir_q   <= DIR_UP;
    end else begin
      prev_q <= lvl_i;
      lock_q <= lock_i;
      if ((|edges) && !lock_i) begin
        valid_q <= 1'b1;
        dir_q   <= edge_to_dir(edges);
      end else if (lock_rise || clear_i) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - arbitrates dbg/btn/pad moves and paces them into the game core
module move_scheduler
  import move_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int FRAME_GAP      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_lvl,
  input  logic [3:0] pad_lvl,
  input  logic [3:0] dbg_pulse,
  input  logic       lock,
  input  logic       frame_tick,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic       move_dbg,
  input  logic       move_ready,
  input  logic       move_done,
  output logic       start_pulse,
  output logic       busy,
  output logic       timeout_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int FW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FR_LAST = FW'(FRAME_GAP - 1);

  state_e        state_q;
  logic          move_valid_q, move_dbg_q, start_pulse_q, timeout_err_q;
  logic [1:0]    move_dir_q;
  logic [TW-1:0] to_cnt_q;
  logic [FW-1:0] fr_cnt_q;
  logic          dbg_valid_q;
  logic [1:0]    dbg_dir_q;

  logic       btn_v, pad_v, btn_sp, pad_sp;
  logic [1:0] btn_d, pad_d;
  logic       idle, clr_dbg, clr_btn, clr_pad;

  // Fixed priority dbg > btn > pad; the winner's slot clears as ISSUE is entered.
  assign idle    = (state_q == S_IDLE);
  assign clr_dbg = idle & dbg_valid_q;
  assign clr_btn = idle & ~dbg_valid_q & btn_v;
  assign clr_pad = idle & ~dbg_valid_q & ~btn_v & pad_v;

  move_src_capture u_btn (
    .clk(clk), .rst_n(rst_n), .lvl_i(btn_lvl), .lock_i(lock), .clear_i(clr_btn),
    .slot_valid_o(btn_v), .slot_dir_o(btn_d), .press_locked_o(btn_sp)
  );

  move_src_capture u_pad (
    .clk(clk), .rst_n(rst_n), .lvl_i(pad_lvl), .lock_i(lock), .clear_i(clr_pad),
    .slot_valid_o(pad_v), .slot_dir_o(pad_d), .press_locked_o(pad_sp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      move_valid_q  <= 1'b0;
      move_dir_q    <= DIR_UP;
      move_dbg_q    <= 1'b0;
      start_pulse_q <= 1'b0;
      timeout_err_q <= 1'b0;
      to_cnt_q      <= '0;
      fr_cnt_q      <= '0;
      dbg_valid_q   <= 1'b0;
      dbg_dir_q     <= DIR_UP;
    end else begin
      start_pulse_q <= btn_sp | pad_sp;
      timeout_err_q <= 1'b0;
      if (|dbg_pulse) begin
        dbg_valid_q <= 1'b1;
        dbg_dir_q   <= edge_to_dir(dbg_pulse);
      end else if (clr_dbg) begin
        dbg_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (dbg_valid_q || btn_v || pad_v) begin
            move_valid_q <= 1'b1;
            move_dbg_q   <= dbg_valid_q;
            move_dir_q   <= dbg_valid_q ? dbg_dir_q : (btn_v ? btn_d : pad_d);
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (move_ready) begin
            move_valid_q <= 1'b0;
            to_cnt_q     <= '0;
            state_q      <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (move_done) begin
            fr_cnt_q <= '0;
            state_q  <= (FRAME_GAP == 0) ? S_IDLE : S_WAIT_FRAME;
          end else if (to_cnt_q == TO_LAST) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        S_WAIT_FRAME: begin
          if (frame_tick) begin
            if (fr_cnt_q == FR_LAST) state_q  <= S_IDLE;
            else                     fr_cnt_q <= fr_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign move_valid  = move_valid_q;
  assign move_dir    = move_dir_q;
  assign move_dbg    = move_dbg_q;
  assign start_pulse = start_pulse_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_move_scheduler.sv
// tb/tb_move_scheduler.sv - directed and random checks of move_scheduler against a behavioural model
module tb_move_scheduler;

  localparam int TO = 15;
  localparam int FG = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_lvl = '0, pad_lvl = '0, dbg_pulse = '0;
  logic       lock = 1'b0, frame_tick = 1'b0, move_ready = 1'b0, move_done = 1'b0;
  logic       move_valid, move_dbg, start_pulse, busy, timeout_err;
  logic [1:0] move_dir;

  move_scheduler #(.TIMEOUT_CYCLES(TO), .FRAME_GAP(FG)) dut (
    .clk(clk), .rst_n(rst_n), .btn_lvl(btn_lvl), .pad_lvl(pad_lvl),
    .dbg_pulse(dbg_pulse), .lock(lock), .frame_tick(frame_tick),
    .move_valid(move_valid), .move_dir(move_dir), .move_dbg(move_dbg),
    .move_ready(move_ready), .move_done(move_done), .start_pulse(start_pulse),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Model: sources 0=dbg, 1=btn, 2=pad; phase 0=idle 1=offer 2=await core 3=await frames
  int         m_v[3], m_d[3];
  logic [3:0] m_prev[2];
  logic       m_lock_prev;
  int         phase, waited, ticks;
  int         m_valid, m_dir, m_dbg, m_sp, m_to;

  function automatic int lowbit(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_step();
    int win;
    logic [3:0] lv[2];
    logic [3:0] ev;
    logic lock_rise;
    if (!rst_n) begin
      for (int s = 0; s < 3; s++) begin m_v[s] = 0; m_d[s] = 0; end
      m_prev[0] = 4'hf; m_prev[1] = 4'hf; m_lock_prev = 1'b0;
      phase = 0; waited = 0; ticks = 0;
      m_valid = 0; m_dir = 0; m_dbg = 0; m_sp = 0; m_to = 0;
      return;
    end
    win = -1;
    if (phase == 0)
      for (int s = 0; s < 3; s++) if (win < 0 && m_v[s] != 0) win = s;
    lv[0] = btn_lvl; lv[1] = pad_lvl;
    lock_rise = lock && !m_lock_prev;
    m_sp = 0; m_to = 0;
    case (phase)
      0: if (win >= 0) begin m_valid = 1; m_dir = m_d[win]; m_dbg = (win == 0); phase = 1; end
      1: if (move_ready) begin m_valid = 0; phase = 2; waited = 0; end
      2: if (move_done) begin phase = (FG == 0) ? 0 : 3; ticks = 0; end
         else begin
           waited++;
           if (waited == TO) begin m_to = 1; phase = 0; end
         end
      3: if (frame_tick) begin ticks++; if (ticks == FG) phase = 0; end
      default: phase = 0;
    endcase
    if (dbg_pulse != 0) begin m_v[0] = 1; m_d[0] = lowbit(dbg_pulse); end
    else if (win == 0) m_v[0] = 0;
    for (int s = 0; s < 2; s++) begin
      ev = lv[s] & ~m_prev[s];
      if (ev != 0 && lock) m_sp = 1;
      if (ev != 0 && !lock) begin m_v[s+1] = 1; m_d[s+1] = lowbit(ev); end
      else if (lock_rise || win == s + 1) m_v[s+1] = 0;
      m_prev[s] = lv[s];
    end
    m_lock_prev = lock;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("valid", move_valid, m_valid);
    chk("dir", move_dir, m_dir);
    chk("dbg", move_dbg, m_dbg);
    chk("busy", busy, (phase != 0) ? 1 : 0);
    chk("start_pulse", start_pulse, m_sp);
    chk("timeout_err", timeout_err, m_to);
  endtask

  task automatic finish_move();
    move_ready = 1'b1;
    cyc();
    move_done = 1'b1; cyc(); move_done = 1'b0;
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0; cyc(); cyc();
    chk("rst_valid", move_valid, 0); chk("rst_busy", busy, 0);
    chk("rst_sp", start_pulse, 0); chk("rst_to", timeout_err, 0);
    rst_n = 1'b1; move_ready = 1'b1;
    repeat (3) cyc();

    // Single button press, latency and frame pacing
    btn_lvl = 4'b0001; cyc(); chk("s1_lat1", move_valid, 0);
    cyc(); chk("s1_valid", move_valid, 1); chk("s1_dir", move_dir, 0); chk("s1_dbg", move_dbg, 0);
    cyc(); chk("s1_drop", move_valid, 0); chk("s1_busy", busy, 1);
    btn_lvl = 4'b0000; repeat (5) cyc();
    move_done = 1'b1; cyc(); move_done = 1'b0; chk("s1_wait_frame", busy, 1);
    cyc(); cyc(); chk("s1_still_busy", busy, 1);
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0; chk("s1_idle", busy, 0);

    // Debug beats pad raised in the same cycle
    dbg_pulse = 4'b1000; pad_lvl = 4'b0010; cyc(); dbg_pulse = 4'b0000;
    cyc(); chk("s2_dir", move_dir, 3); chk("s2_dbg", move_dbg, 1); chk("s2_valid", move_valid, 1);
    finish_move();
    cyc(); chk("s2_pad_valid", move_valid, 1); chk("s2_pad_dir", move_dir, 1); chk("s2_pad_dbg", move_dbg, 0);
    pad_lvl = 4'b0000; finish_move();

    // Lock turns presses into start pulses
    lock = 1'b1; cyc();
    btn_lvl = 4'b0001; cyc(); chk("s3_sp", start_pulse, 1); chk("s3_novalid", move_valid, 0);
    btn_lvl = 4'b0000; cyc(); chk("s3_sp_end", start_pulse, 0);
    cyc(); chk("s3_still_none", move_valid, 0);
    lock = 1'b0; cyc();
    btn_lvl = 4'b0100; cyc(); cyc(); chk("s3_left", move_dir, 2); chk("s3_left_v", move_valid, 1);
    btn_lvl = 4'b0000; finish_move();

    // Timeout with a pad move queued behind it
    btn_lvl = 4'b0010; cyc(); btn_lvl = 4'b0000; cyc(); cyc();
    for (int k = 1; k <= TO; k++) begin
      pad_lvl = (k == 1) ? 4'b1000 : 4'b0000;
      cyc();
      chk("s4_timeout", timeout_err, (k == TO) ? 1 : 0);
    end
    chk("s4_idle", busy, 0);
    cyc(); chk("s4_next", move_valid, 1); chk("s4_next_dir", move_dir, 3);
    finish_move();

    // Overwrite while busy
    dbg_pulse = 4'b0001; cyc(); dbg_pulse = 4'b0000; cyc(); cyc();
    btn_lvl = 4'b0001; cyc(); btn_lvl = 4'b0000; cyc();
    btn_lvl = 4'b1000; cyc(); btn_lvl = 4'b0000; cyc();
    move_done = 1'b1; cyc(); move_done = 1'b0;
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    cyc(); chk("s5_over_dir", move_dir, 3); chk("s5_over_v", move_valid, 1);
    finish_move();
    repeat (3) cyc(); chk("s5_only_one", move_valid, 0);

    // Held through reset, then ready stalled, then reset mid-ISSUE
    btn_lvl = 4'b0001; rst_n = 1'b0; cyc(); rst_n = 1'b1;
    repeat (3) cyc(); chk("s5_held_none", move_valid, 0); chk("s5_held_idle", busy, 0);
    move_ready = 1'b0;
    btn_lvl = 4'b0000; cyc(); btn_lvl = 4'b0001; cyc(); cyc();
    chk("s6_valid", move_valid, 1);
    for (int k = 0; k < 50; k++) begin
      cyc(); chk("s6_hold_v", move_valid, 1); chk("s6_hold_dir", move_dir, 0);
    end
    rst_n = 1'b0; cyc();
    chk("s6_rst_v", move_valid, 0); chk("s6_rst_dir", move_dir, 0); chk("s6_rst_dbg", move_dbg, 0);
    chk("s6_rst_busy", busy, 0); chk("s6_rst_to", timeout_err, 0); chk("s6_rst_sp", start_pulse, 0);
    rst_n = 1'b1; btn_lvl = 4'b0000;
    repeat (3) cyc(); chk("s6_after_rst", move_valid, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) btn_lvl = 4'($urandom);
      if ($urandom_range(0, 7) == 0) pad_lvl = 4'($urandom);
      dbg_pulse  = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      if ($urandom_range(0, 63) == 0) lock = ~lock;
      frame_tick = ($urandom_range(0, 5) == 0);
      move_ready = ($urandom_range(0, 1) == 0);
      move_done  = ($urandom_range(0, 9) == 0);
      rst_n      = ($urandom_range(0, 399) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
